// File: rtl/acumulador_exec.sv
// Accumulator execution stage: latches opcode/operand on exec and applies it to acc one cycle later.
// Optional build macro ACUM_SAT_EN turns soma/sub into saturating operations.
module acumulador_exec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             exec,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ilegal
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  localparam logic [3:0] OP_SOMA  = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_ESQ   = 4'd6;
  localparam logic [3:0] OP_DIR   = 4'd7;
  localparam logic [3:0] OP_CARGA = 4'd8;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] din_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_legal;

  // Result of the latched command, evaluated against the current accumulator.
  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, din_q};
    diff      = {1'b0, acc} - {1'b0, din_q};
    res       = acc;
    res_carry = carry;
    res_legal = 1'b1;
    case (op_q)
      OP_SOMA: begin
        res_carry = sum[WIDTH];
`ifdef ACUM_SAT_EN
        res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        res = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        res_carry = diff[WIDTH];
`ifdef ACUM_SAT_EN
        res = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        res = diff[WIDTH-1:0];
`endif
      end
      OP_AND: begin
        res       = acc & din_q;
        res_carry = 1'b0;
      end
      OP_OR: begin
        res       = acc | din_q;
        res_carry = 1'b0;
      end
      OP_XOR: begin
        res       = acc ^ din_q;
        res_carry = 1'b0;
      end
      OP_NOT: begin
        res       = ~acc;
        res_carry = 1'b0;
      end
      OP_ESQ: begin
        res       = {acc[WIDTH-2:0], 1'b0};
        res_carry = acc[WIDTH-1];
      end
      OP_DIR: begin
        res       = {1'b0, acc[WIDTH-1:1]};
        res_carry = acc[0];
      end
      OP_CARGA: begin
        res       = din_q;
        res_carry = 1'b0;
      end
      default: res_legal = 1'b0;
    endcase
  end

  // Control FSM with registered status outputs; reset is synchronous and overrides any command.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      din_q  <= '0;
      acc    <= '0;
      zero   <= 1'b1;
      carry  <= 1'b0;
      neg    <= 1'b0;
      ilegal <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (exec) begin
            op_q  <= op;
            din_q <= din;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (res_legal) begin
            acc    <= res;
            carry  <= res_carry;
            zero   <= (res == '0);
            neg    <= res[WIDTH-1];
            ilegal <= 1'b0;
          end else begin
            ilegal <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_exec.sv
// Self-checking bench for acumulador_exec (WIDTH=8) against an integer-arithmetic reference model.
module tb_acumulador_exec;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   op;
  logic [W-1:0] din;
  logic         exec;
  logic         busy, done, zero, carry, neg, ilegal;
  logic [W-1:0] acc;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  int m_acc;
  bit m_zero, m_carry, m_neg, m_ilegal;

  acumulador_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op(op), .din(din), .exec(exec),
    .busy(busy), .done(done), .acc(acc), .zero(zero),
    .carry(carry), .neg(neg), .ilegal(ilegal)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_acc = 0; m_zero = 1; m_carry = 0; m_neg = 0; m_ilegal = 0;
  endtask

  task automatic model_apply(input int o, input int b);
    int a, s;
    a = m_acc;
    s = a;
    case (o)
      0: begin
        s = a + b;
        m_carry = (s > MAX);
`ifdef ACUM_SAT_EN
        if (s > MAX) s = MAX;
`else
        s = s % (MAX + 1);
`endif
      end
      1: begin
        m_carry = (a < b);
`ifdef ACUM_SAT_EN
        s = (a < b) ? 0 : a - b;
`else
        s = (a < b) ? a - b + MAX + 1 : a - b;
`endif
      end
      2: begin s = a & b; m_carry = 0; end
      3: begin s = a | b; m_carry = 0; end
      4: begin s = a ^ b; m_carry = 0; end
      5: begin s = MAX - a; m_carry = 0; end
      6: begin m_carry = (a >= (MAX + 1) / 2); s = (a * 2) % (MAX + 1); end
      7: begin m_carry = (a % 2 == 1); s = a / 2; end
      8: begin s = b; m_carry = 0; end
      default: begin
        m_ilegal = 1;
        return;
      end
    endcase
    m_acc    = s;
    m_zero   = (s == 0);
    m_neg    = (s >= (MAX + 1) / 2);
    m_ilegal = 0;
  endtask

  function automatic logic [W+3:0] model_vec();
    logic [W-1:0] a;
    a = m_acc[W-1:0];
    return {a, m_zero, m_carry, m_neg, m_ilegal};
  endfunction

  // Issues one command from a negedge; returns busy/done seen after the latch edge.
  // Leaves time at completion edge + 1, with op/din scrambled to prove the command was latched.
  task automatic drive_cmd(input logic [3:0] o, input logic [W-1:0] d,
                           output logic b_seen, output logic d_seen);
    @(negedge clk);
    exec = 1'b1; op = o; din = d;
    @(posedge clk); #1;
    b_seen = busy; d_seen = done;
    exec = 1'b0; op = 4'($urandom); din = W'($urandom);
    @(posedge clk); #1;
    model_apply(int'(o), int'(d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; exec = 1'b1; op = 4'd8; din = 8'hAA;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; exec = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [W+3:0] obs;
    do_reset();
    obs = {acc, zero, carry, neg, ilegal};
    n_cmp++;
    if (obs !== model_vec() || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: acc/z/c/n/il=%h busy=%b done=%b, want %h busy=0 done=0",
               obs, busy, done, model_vec());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drops_exec: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_load_neg();
    logic b_seen, d_seen;
    logic [W+3:0] obs;
    drive_cmd(4'd8, 8'h80, b_seen, d_seen);
    n_cmp++;
    if (b_seen !== 1'b1 || d_seen !== 1'b0) begin
      n_err++;
      $display("FAIL latch_cycle: busy=%b done=%b, want busy=1 done=0", b_seen, d_seen);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_cycle: done=%b busy=%b, want done=1 busy=0", done, busy);
    end
    obs = {acc, zero, carry, neg, ilegal};
    n_cmp++;
    if (obs !== model_vec() || acc !== 8'h80 || neg !== 1'b1 || zero !== 1'b0) begin
      n_err++;
      $display("FAIL load_80: got %h, want %h", obs, model_vec());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_one_cycle: done=%b, want 0", done);
    end
  endtask

  // Table-driven sequences of directed commands, each result checked against the model.
  task automatic test_directed();
    logic [3:0]   ops [12] = '{4'd8, 4'd0, 4'd8, 4'd1, 4'd8, 4'd6, 4'd7, 4'd5,
                               4'd8, 4'd12, 4'd4, 4'd15};
    logic [W-1:0] ds  [12] = '{8'hF0, 8'h20, 8'h05, 8'h07, 8'h81, 8'h00, 8'h00, 8'h00,
                               8'h3C, 8'h99, 8'h3C, 8'h00};
    logic b_seen, d_seen;
    logic [W+3:0] obs;
    for (int i = 0; i < 12; i++) begin
      drive_cmd(ops[i], ds[i], b_seen, d_seen);
      obs = {acc, zero, carry, neg, ilegal};
      n_cmp++;
      if (obs !== model_vec() || done !== 1'b1) begin
        n_err++;
        $display("FAIL directed_%0d op=%0d din=%h: acc/z/c/n/il=%h done=%b, want %h done=1",
                 i, ops[i], ds[i], obs, done, model_vec());
      end
    end
  endtask

  task automatic test_reset_in_exec();
    logic [W+3:0] obs;
    @(negedge clk);
    exec = 1'b1; op = 4'd8; din = 8'h55;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1; exec = 1'b0;
    @(posedge clk); #1;
    model_reset();
    obs = {acc, zero, carry, neg, ilegal};
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || obs !== model_vec()) begin
      n_err++;
      $display("FAIL reset_in_exec: done=%b busy=%b state=%h, want done=0 busy=0 %h",
               done, busy, obs, model_vec());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic b_seen, d_seen;
    int dones = 0;
    bit prev_done = 0;
    bit double_done = 0;
    drive_cmd(4'd8, 8'h00, b_seen, d_seen);
    @(negedge clk);
    exec = 1'b1; op = 4'd0; din = 8'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        model_apply(0, 3);
        if (prev_done) double_done = 1;
      end
      prev_done = done;
    end
    @(negedge clk);
    exec = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dones !== 5 || double_done) begin
      n_err++;
      $display("FAIL b2b_rate: dones=%0d consecutive=%0d, want 5 and 0", dones, double_done);
    end
    n_cmp++;
    if (acc !== 8'(m_acc) || m_acc != 15 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_result: acc=%h busy=%b, want %h busy=0", acc, busy, 8'(m_acc));
    end
  endtask

  task automatic test_random();
    logic b_seen, d_seen;
    logic [W+3:0] obs;
    logic [3:0]   o;
    logic [W-1:0] d;
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      d = W'($urandom);
      drive_cmd(o, d, b_seen, d_seen);
      obs = {acc, zero, carry, neg, ilegal};
      n_cmp++;
      if (obs !== model_vec() || b_seen !== 1'b1 || done !== 1'b1) begin
        n_err++;
        $display("FAIL random_%0d op=%0d din=%h: got %h busy=%b done=%b, want %h",
                 i, o, d, obs, b_seen, done, model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; exec = 1'b0; op = '0; din = '0;
    model_reset();
    test_reset();
    test_load_neg();
    test_directed();
    test_reset_in_exec();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
